// File: rtl/voice_alloc_pkg.sv
// Shared definitions for the voice allocator slice.
// Holds the system-wide defaults for voice count and MIDI payload width, and the
// per-cycle note-on decision type used by the allocator.
// Build option: define VOICE_ALLOC_STEAL_EN to steal the oldest voice when all are busy;
// leave it undefined to drop the note-on and raise the sticky dropped_o flag instead.
package voice_alloc_pkg;

  localparam int unsigned OSC_VOICES        = 7;
  localparam int unsigned MIDI_PAYLOAD_BITS = 7;

  // Outcome of a note-on request in the current cycle.
  typedef enum logic [2:0] {
    OnNone,
    OnRetrig,
    OnAlloc,
    OnSteal,
    OnDrop
  } onAction_e;

endpackage

// File: rtl/bitcount.sv
// Population count of a bit vector.
// Ports:
//   bits_i  : input vector
//   count_o : number of set bits in bits_i
module bitcount #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNT_BW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]  bits_i,
  output logic [CNT_BW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CNT_BW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/voice_lru.sv
// LRU rank keeper for the voice allocator.
// Ranks are a permutation of 0..VOICES-1; rank 0 is the most recently assigned voice.
// Ports:
//   clk_i, nrst_i : clock, asynchronous active-low reset (rank of voice v resets to v)
//   assignStrb_i  : move assignIdx_i to rank 0 this cycle
//   assignIdx_i   : voice being assigned
//   oldestIdx_o   : voice currently holding rank VOICES-1
module voice_lru
  import voice_alloc_pkg::*;
#(
  parameter int unsigned VOICES = OSC_VOICES,
  parameter int unsigned IDX_BW = $clog2(VOICES)
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              assignStrb_i,
  input  logic [IDX_BW-1:0] assignIdx_i,
  output logic [IDX_BW-1:0] oldestIdx_o
);

  logic [IDX_BW-1:0] rank_q [VOICES];
  logic [IDX_BW-1:0] rank_d [VOICES];

  // Voices younger than the one being assigned age by one; that keeps the permutation.
  always_comb begin
    rank_d = rank_q;
    if (assignStrb_i) begin
      for (int v = 0; v < VOICES; v++) begin
        if (IDX_BW'(v) == assignIdx_i) begin
          rank_d[v] = '0;
        end else if (rank_q[v] < rank_q[assignIdx_i]) begin
          rank_d[v] = rank_q[v] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    oldestIdx_o = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (rank_q[v] == IDX_BW'(VOICES - 1)) oldestIdx_o = IDX_BW'(v);
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int v = 0; v < VOICES; v++) rank_q[v] <= IDX_BW'(v);
    end else begin
      rank_q <= rank_d;
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator.
// Assigns note-on requests to free voices (lowest index first), retriggers a voice already
// sounding the same note, releases on note-off, and tracks LRU age for voice stealing.
// Build option VOICE_ALLOC_STEAL_EN: when defined a note-on with all voices busy steals the
// oldest voice; when undefined it is dropped and the sticky dropped_o output is set
// (cleared by allOff_i or reset). dropped_o only exists in the non-stealing build.
// Ports:
//   clk_i, nrst_i    : clock, asynchronous active-low reset
//   note_i           : note number qualified by either strobe
//   noteOnStrb_i     : note-on request (ignored when noteOffStrb_i is also high)
//   noteOffStrb_i    : note-off request
//   allOff_i         : synchronous release of all voices
//   voiceNote_o      : flattened per-voice note, voice v at [v*NOTE_BW +: NOTE_BW]
//   voiceGate_o      : per-voice gate
//   retrigStrb_o     : one-cycle pulse on the voice just (re)assigned
//   activeCnt_o      : number of gated voices
//   busy_o           : all voices gated
//   dropped_o        : sticky "note-on was dropped" flag (non-stealing build only)
module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int unsigned VOICES  = OSC_VOICES,
  parameter int unsigned NOTE_BW = MIDI_PAYLOAD_BITS,
  parameter int unsigned CNT_BW  = $clog2(VOICES + 1),
  parameter int unsigned IDX_BW  = $clog2(VOICES)
) (
  input  logic                      clk_i,
  input  logic                      nrst_i,
  input  logic [NOTE_BW-1:0]        note_i,
  input  logic                      noteOnStrb_i,
  input  logic                      noteOffStrb_i,
  input  logic                      allOff_i,
  output logic [VOICES*NOTE_BW-1:0] voiceNote_o,
  output logic [VOICES-1:0]         voiceGate_o,
  output logic [VOICES-1:0]         retrigStrb_o,
  output logic [CNT_BW-1:0]         activeCnt_o,
  output logic                      busy_o
`ifdef VOICE_ALLOC_STEAL_EN
`else
  ,
  output logic                      dropped_o
`endif
);

  logic [NOTE_BW-1:0] note_q [VOICES];
  logic [NOTE_BW-1:0] note_d [VOICES];
  logic [VOICES-1:0]  gate_q, gate_d;
  logic [VOICES-1:0]  retrig_q, retrig_d;
  logic [VOICES-1:0]  matchVec;
  logic [IDX_BW-1:0]  hitIdx, freeIdx, oldestIdx, tgtIdx;
  logic               hit, freeAvail, lruStrb;
  onAction_e          onAct;

`ifdef VOICE_ALLOC_STEAL_EN
`else
  logic dropped_q, dropped_d;
  logic unusedOldest;
  assign unusedOldest = ^oldestIdx;
`endif

  // Lowest-index gated voice holding note_i, and lowest-index free voice.
  always_comb begin
    hitIdx  = '0;
    freeIdx = '0;
    for (int v = 0; v < VOICES; v++) begin
      matchVec[v] = gate_q[v] && (note_q[v] == note_i);
    end
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (matchVec[v]) hitIdx = IDX_BW'(v);
      if (!gate_q[v])  freeIdx = IDX_BW'(v);
    end
    hit       = |matchVec;
    freeAvail = ~&gate_q;
  end

  // Note-on decision; allOff and note-off take precedence.
  always_comb begin
    onAct  = OnNone;
    tgtIdx = '0;
    if (noteOnStrb_i && !noteOffStrb_i && !allOff_i) begin
      if (hit) begin
        onAct  = OnRetrig;
        tgtIdx = hitIdx;
      end else if (freeAvail) begin
        onAct  = OnAlloc;
        tgtIdx = freeIdx;
      end else begin
`ifdef VOICE_ALLOC_STEAL_EN
        onAct  = OnSteal;
        tgtIdx = oldestIdx;
`else
        onAct  = OnDrop;
`endif
      end
    end
  end

  always_comb begin
    note_d   = note_q;
    gate_d   = gate_q;
    retrig_d = '0;
    lruStrb  = 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
`else
    dropped_d = dropped_q;
`endif
    if (allOff_i) begin
      gate_d = '0;
`ifdef VOICE_ALLOC_STEAL_EN
`else
      dropped_d = 1'b0;
`endif
    end else if (noteOffStrb_i) begin
      // Note is held so the release tail keeps its pitch.
      gate_d = gate_q & ~matchVec;
    end else begin
      case (onAct)
        OnRetrig: begin
          retrig_d[tgtIdx] = 1'b1;
          lruStrb          = 1'b1;
        end
        OnAlloc, OnSteal: begin
          note_d[tgtIdx]   = note_i;
          gate_d[tgtIdx]   = 1'b1;
          retrig_d[tgtIdx] = 1'b1;
          lruStrb          = 1'b1;
        end
        OnDrop: begin
`ifdef VOICE_ALLOC_STEAL_EN
`else
          dropped_d = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int v = 0; v < VOICES; v++) note_q[v] <= '0;
      gate_q   <= '0;
      retrig_q <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
`else
      dropped_q <= 1'b0;
`endif
    end else begin
      note_q   <= note_d;
      gate_q   <= gate_d;
      retrig_q <= retrig_d;
`ifdef VOICE_ALLOC_STEAL_EN
`else
      dropped_q <= dropped_d;
`endif
    end
  end

  voice_lru #(
    .VOICES (VOICES),
    .IDX_BW (IDX_BW)
  ) u_lru (
    .clk_i        (clk_i),
    .nrst_i       (nrst_i),
    .assignStrb_i (lruStrb),
    .assignIdx_i  (tgtIdx),
    .oldestIdx_o  (oldestIdx)
  );

  bitcount #(
    .WIDTH  (VOICES),
    .CNT_BW (CNT_BW)
  ) u_cnt (
    .bits_i  (gate_q),
    .count_o (activeCnt_o)
  );

  for (genvar v = 0; v < VOICES; v++) begin : g_note
    assign voiceNote_o[v*NOTE_BW +: NOTE_BW] = note_q[v];
  end

  assign voiceGate_o  = gate_q;
  assign retrigStrb_o = retrig_q;
  assign busy_o       = &gate_q;
`ifdef VOICE_ALLOC_STEAL_EN
`else
  assign dropped_o = dropped_q;
`endif

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: directed scenarios followed by random strobes, all checked against
// a reference model that tracks voices as plain arrays and LRU age as a newest-first queue.
module tb_voice_alloc;

  localparam int V  = 7;
  localparam int NB = 7;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [NB-1:0] note = '0;
  logic          on = 1'b0, off = 1'b0, allOff = 1'b0;
  logic [V*NB-1:0] voiceNote;
  logic [V-1:0]  gate, retrig;
  logic [CB-1:0] cnt;
  logic          busy;
`ifdef VOICE_ALLOC_STEAL_EN
`else
  logic          dropped;
`endif

  voice_alloc #(
    .VOICES  (V),
    .NOTE_BW (NB)
  ) dut (
    .clk_i         (clk),
    .nrst_i        (nrst),
    .note_i        (note),
    .noteOnStrb_i  (on),
    .noteOffStrb_i (off),
    .allOff_i      (allOff),
    .voiceNote_o   (voiceNote),
    .voiceGate_o   (gate),
    .retrigStrb_o  (retrig),
    .activeCnt_o   (cnt),
    .busy_o        (busy)
`ifdef VOICE_ALLOC_STEAL_EN
`else
    ,
    .dropped_o     (dropped)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  string curTag = "";

  // Reference state.
  int           mNote [V];
  bit           mGate [V];
  int           mOrder [$];  // voice indices, newest first
  bit           mDropped;
  logic [V-1:0] mRetrig;

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0h expected=%0h", curTag, name, obs, exp);
    end
  endtask

  task automatic modelReset();
    mOrder = {};
    for (int v = 0; v < V; v++) begin
      mNote[v] = 0;
      mGate[v] = 0;
      mOrder.push_back(v);
    end
    mDropped = 0;
    mRetrig  = '0;
  endtask

  task automatic touch(int v);
    for (int i = 0; i < mOrder.size(); i++) begin
      if (mOrder[i] == v) begin
        mOrder.delete(i);
        break;
      end
    end
    mOrder.push_front(v);
    mRetrig[v] = 1'b1;
  endtask

  task automatic modelStep(bit doOn, bit doOff, bit doAll, int n);
    int hitV, freeV;
    mRetrig = '0;
    if (doAll) begin
      for (int v = 0; v < V; v++) mGate[v] = 0;
      mDropped = 0;
    end else if (doOff) begin
      for (int v = 0; v < V; v++) if (mGate[v] && mNote[v] == n) mGate[v] = 0;
    end else if (doOn) begin
      hitV = -1;
      freeV = -1;
      for (int v = V - 1; v >= 0; v--) begin
        if (mGate[v] && mNote[v] == n) hitV = v;
        if (!mGate[v]) freeV = v;
      end
      if (hitV >= 0) begin
        touch(hitV);
      end else if (freeV >= 0) begin
        mNote[freeV] = n;
        mGate[freeV] = 1;
        touch(freeV);
      end else begin
`ifdef VOICE_ALLOC_STEAL_EN
        mNote[mOrder[$]] = n;
        touch(mOrder[$]);
`else
        mDropped = 1;
`endif
      end
    end
  endtask

  task automatic checkAll();
    logic [V*NB-1:0] eNote;
    logic [V-1:0]    eGate;
    int              eCnt;
    eCnt = 0;
    for (int v = 0; v < V; v++) begin
      eNote[v*NB +: NB] = NB'(mNote[v]);
      eGate[v] = mGate[v];
      eCnt += int'(mGate[v]);
    end
    chk("gate", 64'(gate), 64'(eGate));
    chk("note", 64'(voiceNote), 64'(eNote));
    chk("retrig", 64'(retrig), 64'(mRetrig));
    chk("activeCnt", 64'(cnt), 64'(eCnt));
    chk("busy", 64'(busy), 64'(eCnt == V));
`ifdef VOICE_ALLOC_STEAL_EN
`else
    chk("dropped", 64'(dropped), 64'(mDropped));
`endif
  endtask

  task automatic step(bit doOn, bit doOff, bit doAll, int n);
    note   = NB'(n);
    on     = doOn;
    off    = doOff;
    allOff = doAll;
    @(posedge clk);
    #1;
    on     = 1'b0;
    off    = 1'b0;
    allOff = 1'b0;
    modelStep(doOn, doOff, doAll, n);
    checkAll();
  endtask

  function automatic logic [NB-1:0] noteOf(int v);
    logic [V*NB-1:0] tmp;
    tmp = voiceNote;
    return tmp[v*NB +: NB];
  endfunction

  initial begin
    int r;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    curTag = "reset";
    checkAll();
    @(negedge clk);
    nrst = 1'b1;

    curTag = "on60";  step(1, 0, 0, 60);
    chk("retrigPulse", 64'(retrig), 64'(7'b0000001));
    curTag = "on64";  step(1, 0, 0, 64);
    chk("retrigPulse", 64'(retrig), 64'(7'b0000010));
    curTag = "on67";  step(1, 0, 0, 67);
    chk("retrigPulse", 64'(retrig), 64'(7'b0000100));
    chk("cnt3", 64'(cnt), 64'd3);

    curTag = "off64"; step(0, 1, 0, 64);
    chk("gate101", 64'(gate), 64'(7'b0000101));
    chk("v1held", 64'(noteOf(1)), 64'd64);
    curTag = "on72";  step(1, 0, 0, 72);
    chk("v1note72", 64'(noteOf(1)), 64'd72);

    curTag = "repress60"; step(1, 0, 0, 60);
    chk("retrig0", 64'(retrig), 64'(7'b0000001));
    curTag = "idle";  step(0, 0, 0, 0);

    curTag = "onoff55miss"; step(1, 1, 0, 55);
    curTag = "on55";        step(1, 0, 0, 55);
    curTag = "onoff55hit";  step(1, 1, 0, 55);
    chk("noRetrig", 64'(retrig), 64'd0);

    curTag = "allOffA"; step(0, 0, 1, 0);
    for (int n = 40; n <= 46; n++) begin
      curTag = $sformatf("fill%0d", n);
      step(1, 0, 0, n);
    end
    chk("busyFull", 64'(busy), 64'd1);
    curTag = "on50full"; step(1, 0, 0, 50);
`ifdef VOICE_ALLOC_STEAL_EN
    chk("steal0", 64'(noteOf(0)), 64'd50);
    chk("stealRetrig", 64'(retrig), 64'(7'b0000001));
`else
    chk("dropSet", 64'(dropped), 64'd1);
    chk("noRetrigDrop", 64'(retrig), 64'd0);
`endif

    curTag = "allOffFull"; step(0, 0, 1, 0);
    chk("cnt0", 64'(cnt), 64'd0);
    chk("busy0", 64'(busy), 64'd0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        // Asynchronous reset between clock edges, mid-burst.
        on = 1'b1;
        note = NB'(41);
        nrst = 1'b0;
        #1;
        modelReset();
        curTag = "asyncReset";
        checkAll();
        on = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
      end
      r = int'($urandom_range(0, 99));
      curTag = $sformatf("rnd%0d", i);
      if (r < 3)       step(0, 0, 1, 40 + int'($urandom_range(0, 9)));
      else if (r < 8)  step(1, 1, 0, 40 + int'($urandom_range(0, 9)));
      else if (r < 38) step(0, 1, 0, 40 + int'($urandom_range(0, 9)));
      else if (r < 92) step(1, 0, 0, 40 + int'($urandom_range(0, 9)));
      else             step(0, 0, 0, 40 + int'($urandom_range(0, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
